// File: rtl/mc_sched_pkg.sv
// Shared types and constants for the multicycle unit scheduler.
package mc_sched_pkg;

  localparam int NUM_MC   = 3;
  localparam int MC_XLEN  = 32;

  // Unit ids double as bit positions in every per-unit vector.
  localparam int MC_FSQRT = 0;
  localparam int MC_DIV   = 1;
  localparam int MC_FDIV  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic               fp;
    logic [MC_XLEN-1:0] data;
  } mc_entry_t;

  // True when a used source operand names the same register (and file) as a
  // pending destination. Integer x0 is hardwired, so it never creates a
  // dependency; FP f0 is an ordinary register and does.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic       fp,
                                     input logic [4:0] rs,
                                     input logic       use_rs,
                                     input logic       src_fp);
    return use_rs && (fp == src_fp) && (rd == rs) && (fp || (rd != 5'd0));
  endfunction

endpackage

// File: rtl/mc_unit_tracker.sv
// Tracks one multicycle unit: IDLE/RUN/DONE state, its destination entry
// and the scoreboard comparators against the ID-stage sources.
module mc_unit_tracker
  import mc_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_i,
  input  logic [4:0]         issue_rd_i,
  input  logic               issue_fp_i,
  input  logic               done_i,
  input  logic [MC_XLEN-1:0] result_i,
  input  logic               retire_i,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic               id_use_rs1_i,
  input  logic               id_use_rs2_i,
  input  logic               id_src_fp_i,
  output logic               start_o,
  output logic               busy_o,
  output logic               done_o,
  output mc_entry_t          entry_o,
  output logic               hit_o
);

  mc_state_e state_q, state_d;
  mc_entry_t entry_q, entry_d;
  logic      pend_hit;
  logic      live_hit;

  // State and entry registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Next state, entry capture and the launch pulse. Issue to a busy unit and
  // done pulses outside RUN are ignored.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    start_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_i) begin
          state_d    = RUN;
          start_o    = 1'b1;
          entry_d.rd = issue_rd_i;
          entry_d.fp = issue_fp_i;
        end
      end
      RUN: begin
        if (done_i) begin
          state_d      = DONE;
          entry_d.data = result_i;
        end
      end
      DONE: begin
        if (retire_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A retiring unit still reports a hit this cycle (conservative), and the
  // live issue is checked regardless of whether the unit accepts it.
  always_comb begin
    pend_hit = (state_q != IDLE) &&
               (reg_match(entry_q.rd, entry_q.fp, id_rs1_i, id_use_rs1_i, id_src_fp_i) ||
                reg_match(entry_q.rd, entry_q.fp, id_rs2_i, id_use_rs2_i, id_src_fp_i));
    live_hit = issue_i &&
               (reg_match(issue_rd_i, issue_fp_i, id_rs1_i, id_use_rs1_i, id_src_fp_i) ||
                reg_match(issue_rd_i, issue_fp_i, id_rs2_i, id_use_rs2_i, id_src_fp_i));
  end

  assign hit_o   = pend_hit | live_hit;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign entry_o = entry_q;

endmodule

// File: rtl/mc_unit_scheduler.sv
// Launches and tracks the multicycle units, arbitrates finished results
// round-robin onto the single writeback port and raises the ID scoreboard hit.
module mc_unit_scheduler
  import mc_sched_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_MC = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MC-1:0]      issue_valid,
  input  logic                   flush_exe,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_fp,
  output logic [NUM_MC-1:0]      unit_start,
  input  logic [NUM_MC-1:0]      unit_done,
  input  logic [NUM_MC*XLEN-1:0] unit_result,
  output logic [NUM_MC-1:0]      unit_busy,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [NUM_MC-1:0]      wb_unit,
  output logic [4:0]             wb_rd,
  output logic                   wb_fp,
  output logic [XLEN-1:0]        wb_data,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic                   id_src_fp,
  output logic                   sb_hit
);

  logic [NUM_MC-1:0] issue_live;
  logic [NUM_MC-1:0] done_mask;
  logic [NUM_MC-1:0] hit_vec;
  logic [NUM_MC-1:0] rr_grant;
  logic [NUM_MC-1:0] grant;
  logic [NUM_MC-1:0] retire;
  mc_entry_t         entries [NUM_MC];

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              lock_valid_q, lock_valid_d;
  logic [NUM_MC-1:0] lock_unit_q, lock_unit_d;

  // A flushed EXE instruction must not launch anything.
  assign issue_live = issue_valid & {NUM_MC{~flush_exe}};
  assign retire     = grant & {NUM_MC{wb_ready}};

  for (genvar gi = 0; gi < NUM_MC; gi++) begin : g_unit
    mc_unit_tracker u_tracker (
      .clk          (clk),
      .reset        (reset),
      .issue_i      (issue_live[gi]),
      .issue_rd_i   (issue_rd),
      .issue_fp_i   (issue_fp),
      .done_i       (unit_done[gi]),
      .result_i     (unit_result[gi*XLEN +: XLEN]),
      .retire_i     (retire[gi]),
      .id_rs1_i     (id_rs1),
      .id_rs2_i     (id_rs2),
      .id_use_rs1_i (id_use_rs1),
      .id_use_rs2_i (id_use_rs2),
      .id_src_fp_i  (id_src_fp),
      .start_o      (unit_start[gi]),
      .busy_o       (unit_busy[gi]),
      .done_o       (done_mask[gi]),
      .entry_o      (entries[gi]),
      .hit_o        (hit_vec[gi])
    );
  end

  assign sb_hit = |hit_vec;

  // Round-robin pick: first DONE unit at or after rr_ptr, wrapping mod 3.
  always_comb begin
    logic       found;
    logic [2:0] sum;
    logic [1:0] cand;
    rr_grant = '0;
    found    = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_MC; k++) begin
      sum  = {1'b0, rr_ptr_q} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && done_mask[cand]) begin
        rr_grant[cand] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Once a result is presented it stays selected until accepted.
  assign grant    = lock_valid_q ? lock_unit_q : rr_grant;
  assign wb_valid = |grant;
  assign wb_unit  = grant;

  // Present the granted entry; zero when nothing is offered.
  always_comb begin
    wb_rd   = '0;
    wb_fp   = 1'b0;
    wb_data = '0;
    for (int i = 0; i < NUM_MC; i++) begin
      if (grant[i]) begin
        wb_rd   = entries[i].rd;
        wb_fp   = entries[i].fp;
        wb_data = entries[i].data;
      end
    end
  end

  // Lock on a stalled offer; on accept, release and advance past the winner.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_unit_d  = lock_unit_q;
    if (wb_valid) begin
      if (wb_ready) begin
        lock_valid_d = 1'b0;
        lock_unit_d  = '0;
        if (grant[0])      rr_ptr_d = 2'd1;
        else if (grant[1]) rr_ptr_d = 2'd2;
        else               rr_ptr_d = 2'd0;
      end else begin
        lock_valid_d = 1'b1;
        lock_unit_d  = grant;
      end
    end
  end

  // Arbiter pointer and lock registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_unit_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_unit_q  <= lock_unit_d;
    end
  end

endmodule

// File: tb/tb_mc_unit_scheduler.sv
// Self-checking bench for mc_unit_scheduler: scoreboard vectors in a table,
// hand sequences for arbitration/lock/flush/reset, writeback scoreboard queue.
module tb_mc_unit_scheduler;

  localparam int XLEN   = 32;
  localparam int NUM_MC = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_MC-1:0]      issue_valid;
  logic                   flush_exe;
  logic [4:0]             issue_rd;
  logic                   issue_fp;
  logic [NUM_MC-1:0]      unit_start;
  logic [NUM_MC-1:0]      unit_done;
  logic [NUM_MC*XLEN-1:0] unit_result;
  logic [NUM_MC-1:0]      unit_busy;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [NUM_MC-1:0]      wb_unit;
  logic [4:0]             wb_rd;
  logic                   wb_fp;
  logic [XLEN-1:0]        wb_data;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic                   id_src_fp;
  logic                   sb_hit;

  always #5 clk = ~clk;

  mc_unit_scheduler #(.XLEN(XLEN), .NUM_MC(NUM_MC)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .flush_exe   (flush_exe),
    .issue_rd    (issue_rd),
    .issue_fp    (issue_fp),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .unit_busy   (unit_busy),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_unit     (wb_unit),
    .wb_rd       (wb_rd),
    .wb_fp       (wb_fp),
    .wb_data     (wb_data),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_src_fp   (id_src_fp),
    .sb_hit      (sb_hit)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  unit;
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;

  typedef struct {
    int         unit;
    logic [4:0] rd;
    logic       fp;
    logic       live;
    logic       flush;
    logic       done_first;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       src_fp;
    logic       exp_hit;
  } sb_vec_t;

  sb_vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    issue_valid = '0;
    flush_exe   = 1'b0;
    issue_rd    = '0;
    issue_fp    = 1'b0;
    unit_done   = '0;
    unit_result = '0;
    wb_ready    = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    id_src_fp   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clr_inputs();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Writeback scoreboard: every accepted result must match the queue head.
  always begin
    @(negedge clk);
    #2;
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_sb_unit", 64'(wb_unit), 64'(mon_e.unit));
        chk("wb_sb_rd",   64'(wb_rd),   64'(mon_e.rd));
        chk("wb_sb_fp",   64'(wb_fp),   64'(mon_e.fp));
        chk("wb_sb_data", 64'(wb_data), 64'(mon_e.data));
      end
    end
  end

  // Issue to a busy unit is an upstream protocol error.
  always begin
    @(negedge clk);
    #3;
    if (!reset && |(issue_valid & ~{NUM_MC{flush_exe}} & unit_busy)) begin
      bad++;
      $display("FAIL issue_to_busy_unit issue=%b busy=%b", issue_valid, unit_busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clr_inputs();

    //                unit rd  fp  live flush done rs1 rs2 u1 u2 sfp exp
    vecs[0] = '{2, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd3,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{2, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  5'd1,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  5'd12, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2,  5'd12, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    do_reset();
    #1;
    chk("reset_start",  64'(unit_start), 64'd0);
    chk("reset_busy",   64'(unit_busy),  64'd0);
    chk("reset_wb",     {59'd0, wb_valid, wb_unit, wb_fp}, 64'd0);
    chk("reset_wbdata", {27'd0, wb_rd, wb_data}, 64'd0);
    chk("reset_sb_hit", 64'(sb_hit), 64'd0);

    // Single DIV: issue at T, done at T+10, writeback at T+11, idle at T+12
    issue_valid = 3'b010; issue_rd = 5'd5; issue_fp = 1'b0;
    #1 chk("t1_start", 64'(unit_start), 64'b010);
    cyc(); issue_valid = '0;
    #1 chk("t1_busy", 64'(unit_busy), 64'b010);
    repeat (8) cyc();
    cyc();
    unit_done = 3'b010; unit_result = {32'h0, 32'h0000_0007, 32'h0}; wb_ready = 1'b1;
    exp_q.push_back('{3'b010, 5'd5, 1'b0, 32'h7});
    #1 chk("t1_no_early_wb", 64'(wb_valid), 64'd0);
    cyc(); unit_done = '0; unit_result = '0;
    #1;
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_unit",  64'(wb_unit),  64'b010);
    chk("t1_wb_rd",    64'(wb_rd),    64'd5);
    chk("t1_wb_data",  64'(wb_data),  64'd7);
    cyc();
    #1 chk("t1_busy_clear", 64'(unit_busy), 64'd0);

    // FSQRT and FDIV finishing together: FSQRT first, then FDIV
    do_reset();
    issue_valid = 3'b001; issue_rd = 5'd1; issue_fp = 1'b1;
    cyc(); issue_valid = 3'b100; issue_rd = 5'd2; issue_fp = 1'b1;
    cyc(); issue_valid = '0;
    unit_done = 3'b101; unit_result = {32'h0000_F00D, 32'h0, 32'h0000_A5A5}; wb_ready = 1'b1;
    exp_q.push_back('{3'b001, 5'd1, 1'b1, 32'hA5A5});
    exp_q.push_back('{3'b100, 5'd2, 1'b1, 32'hF00D});
    cyc(); unit_done = '0; unit_result = '0;
    #1;
    chk("t2_first_unit", 64'(wb_unit),   64'b001);
    chk("t2_both_busy",  64'(unit_busy), 64'b101);
    cyc();
    #1;
    chk("t2_second_unit", 64'(wb_unit),       64'b100);
    chk("t2_one_busy",    64'(unit_busy),     64'b100);
    chk("t2_rr_mid",      64'(dut.rr_ptr_q),  64'd1);
    cyc();
    #1;
    chk("t2_idle",   {62'd0, wb_valid, |unit_busy}, 64'd0);
    chk("t2_rr_end", 64'(dut.rr_ptr_q), 64'd0);

    // DIV held with wb_ready low while FSQRT completes; lock keeps DIV
    do_reset();
    issue_valid = 3'b010; issue_rd = 5'd9; issue_fp = 1'b0;
    cyc(); issue_valid = 3'b001; issue_rd = 5'd4; issue_fp = 1'b0;
    cyc(); issue_valid = '0;
    unit_done = 3'b010; unit_result = {32'h0, 32'hDEAD_BEEF, 32'h0}; wb_ready = 1'b0;
    exp_q.push_back('{3'b010, 5'd9, 1'b0, 32'hDEAD_BEEF});
    for (int k = 0; k < 4; k++) begin
      cyc();
      unit_done   = (k == 1) ? 3'b001 : 3'b000;
      unit_result = (k == 1) ? {32'h0, 32'h0, 32'h0000_0011} : '0;
      if (k == 1) exp_q.push_back('{3'b001, 5'd4, 1'b0, 32'h11});
      #1;
      chk($sformatf("t3_hold_unit%0d", k), 64'(wb_unit), 64'b010);
      chk($sformatf("t3_hold_data%0d", k), 64'(wb_data), 64'hDEAD_BEEF);
    end
    cyc(); unit_done = '0; unit_result = '0; wb_ready = 1'b1;
    #1 chk("t3_accept_unit", 64'(wb_unit), 64'b010);
    cyc();
    #1;
    chk("t3_next_unit", 64'(wb_unit), 64'b001);
    chk("t3_next_data", 64'(wb_data), 64'h11);
    cyc();
    #1 chk("t3_idle", {62'd0, wb_valid, |unit_busy}, 64'd0);

    // Scoreboard table
    foreach (vecs[n]) begin
      do_reset();
      if (!vecs[n].live) begin
        issue_valid = 3'(1 << vecs[n].unit); issue_rd = vecs[n].rd; issue_fp = vecs[n].fp;
        cyc(); issue_valid = '0;
        if (vecs[n].done_first) begin
          unit_done = 3'(1 << vecs[n].unit);
          cyc(); unit_done = '0;
        end
      end else begin
        issue_valid = 3'(1 << vecs[n].unit); issue_rd = vecs[n].rd;
        issue_fp = vecs[n].fp; flush_exe = vecs[n].flush;
      end
      id_rs1 = vecs[n].rs1; id_rs2 = vecs[n].rs2;
      id_use_rs1 = vecs[n].use1; id_use_rs2 = vecs[n].use2; id_src_fp = vecs[n].src_fp;
      #1 chk($sformatf("sb_vec%0d", n), 64'(sb_hit), 64'(vecs[n].exp_hit));
      cyc(); clr_inputs();
    end

    // Flushed issue never launches
    do_reset();
    issue_valid = 3'b010; issue_rd = 5'd6; flush_exe = 1'b1;
    #1 chk("flush_start", 64'(unit_start), 64'd0);
    cyc(); issue_valid = '0; flush_exe = 1'b0;
    #1 chk("flush_busy", 64'(unit_busy), 64'd0);

    // Reset while DIV runs discards it
    do_reset();
    issue_valid = 3'b010; issue_rd = 5'd6;
    cyc(); issue_valid = '0; id_rs1 = 5'd6; id_use_rs1 = 1'b1;
    #1;
    chk("rst_pre_busy", 64'(unit_busy), 64'b010);
    chk("rst_pre_hit",  64'(sb_hit),    64'd1);
    cyc(); reset = 1'b1;
    cyc();
    #1;
    chk("rst_outputs_a", {55'd0, unit_start, unit_busy, wb_valid, wb_unit, wb_fp, sb_hit}, 64'd0);
    chk("rst_outputs_b", {27'd0, wb_rd, wb_data}, 64'd0);
    reset = 1'b0; unit_done = 3'b010; unit_result = {32'h0, 32'h1234, 32'h0};
    cyc(); unit_done = '0;
    #1 chk("rst_done_ignored", {62'd0, wb_valid, |unit_busy}, 64'd0);

    cyc();
    chk("wb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
